alu_bitslice_seq: RTL and testbench
===================================

Name: alu_bitslice_seq

Overview:
- Multi-cycle, parametrised successor to the 2-bit combinational ALU.
- Evaluates a WIDTH-bit 74181-style function (S[3:0], M, carry-in) by iterating one SLICE-bit slice per clock, LSB slice first, with a registered carry.
- Sits behind a start/busy/done handshake so wide operands reuse one narrow slice datapath.
- Also produces zero and carry-out flags.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of SLICE and at least SLICE.
- SLICE, 2, bits processed per clock; N = WIDTH/SLICE slices per operation.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  function select.
- m  input  1  mode: 1 = logic, 0 = arithmetic.
- cin  input  1  active-high carry-in, arithmetic only.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when f/cout/zero are updated.
- f  output  WIDTH  result; held until the next done.
- cout  output  1  carry out of the MSB slice; 0 in logic mode.
- zero  output  1  high when f == 0; registered with f.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the slice counter and carry register are 0. Reset takes effect immediately, including mid-operation; an aborted operation never pulses done.
- FSM states are IDLE and RUN.
- IDLE with start=1 at a clock edge:
  - latch a, b, s, m, cin;
  - set the carry register to cin when m=0, or to 0 when m=1;
  - clear the counter;
  - go to RUN with busy=1.
- RUN, each edge:
  - compute slice k = counter;
  - store the result bits [k*SLICE +: SLICE] into a shadow register;
  - update the carry register;
  - increment the counter.
- On the edge that completes slice N-1:
  - copy the shadow register to f;
  - update cout and zero;
  - drive done=1 for exactly one cycle;
  - drop busy to 0;
  - return to IDLE.
- Latency: the start edge is followed by exactly N edges; done is visible in the cycle after the Nth RUN edge. With the defaults N=4.
- start while busy=1 is ignored. Start is accepted in the same cycle that done is high, giving back-to-back operation.
- Input changes during RUN have no effect because operands are latched.
- Logic mode (m=1), applied bitwise with no carry:
  - 0000 ~A; 0001 ~(A|B); 0010 ~A&B; 0011 0; 0100 ~(A&B); 0101 ~B; 0110 A^B; 0111 A&~B;
  - 1000 ~A|B; 1001 ~(A^B); 1010 B; 1011 A&B; 1100 all ones; 1101 A|~B; 1110 A|B; 1111 A.
- Arithmetic mode (m=0): F = T1 + T2 + carry, with T1/T2 formed bitwise per slice and the carry chained across slices. Ones means all-ones. Per select code, T1 / T2:
  - 0000 A / 0; 0001 A|B / 0; 0010 A|~B / 0; 0011 0 / ones;
  - 0100 A / A&~B; 0101 A|B / A&~B; 0110 A / ~B; 0111 A&~B / ones;
  - 1000 A / A&B; 1001 A / B; 1010 A|~B / A&B; 1011 A&B / ones;
  - 1100 A / A; 1101 A|B / A; 1110 A|~B / A; 1111 A / ones.
- cout is the carry out of the MSB slice, with natural wrap-around; for example 0xFF + 1 gives f=0x00, cout=1.

Optional Feature:
- Macro: ALU_OVF_EN.
- When defined:
  - an extra output, ovf (1 bit), is registered alongside f;
  - in arithmetic mode ovf = carry into the MSB XOR carry out of the MSB (two's-complement overflow);
  - in logic mode ovf = 0;
  - ovf resets to 0.
- When undefined, the port and its logic are absent and all other behaviour is identical.

Test Plan:
- WIDTH=8, SLICE=2, a=0x01, b=0x02, s=1001, m=0, cin=0, pulse start → busy for 4 cycles, done one cycle later; f=0x03, cout=0, zero=0.
- a=0xFF, b=0x01, s=1001, m=0, cin=0 → f=0x00, cout=1, zero=1.
- a=0x05, b=0x03, s=0110, m=0, cin=1 (subtract) → f=0x02, cout=1. With cin=0 → f=0x01.
- a=0xA5, b=0x0F, s=0110, m=1 → f=0xAA, cout=0. Then s=0011, m=1 → f=0x00, zero=1.
- Start, then start again with different operands at cycle 2 → the second request is ignored and f matches the first. Start asserted in the done cycle → accepted, and done again 4 cycles later.
- Assert rst during cycle 2 of RUN → busy, done, f, cout and zero read 0 immediately, and no done follows. With ALU_OVF_EN defined: a=0x7F, b=0x01, s=1001, m=0, cin=0 → f=0x80, ovf=1, cout=0.

Source files
------------

// File: rtl/alu_bitslice_seq.sv
// Multi-cycle 74181-style ALU: evaluates WIDTH bits one SLICE-bit slice per clock behind a start/busy/done handshake.
// Optional two's-complement overflow output ovf is enabled by defining ALU_OVF_EN.
module alu_bitslice_seq #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             zero
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, shadow_q, shadow_d;
  logic [3:0]        s_q;
  logic              m_q, carry_q;
  logic [CW-1:0]     cnt_q;
  logic              last;

  logic [SLICE-1:0]  sa, sb, t1, t2, lf, csum, slice_f;
  logic              c, slice_c;
`ifdef ALU_OVF_EN
  logic              c_msb, slice_cm;
`endif

  assign busy = (state_q == RUN);
  assign last = (cnt_q == CW'(N - 1));

  // One slice of the datapath: operand terms, bitwise ripple, and the logic-mode result.
  // NOTE: every variable driven here gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    sa   = a_q[cnt_q*SLICE +: SLICE];
    sb   = b_q[cnt_q*SLICE +: SLICE];
    t1   = '0;
    t2   = '0;
    lf   = '0;
    csum = '0;
    c    = carry_q;
`ifdef ALU_OVF_EN
    c_msb = carry_q;
`endif
    unique case (s_q)
      4'h0: begin lf = ~sa;         t1 = sa;        t2 = '0;        end
      4'h1: begin lf = ~(sa | sb);  t1 = sa | sb;   t2 = '0;        end
      4'h2: begin lf = ~sa & sb;    t1 = sa | ~sb;  t2 = '0;        end
      4'h3: begin lf = '0;          t1 = '0;        t2 = '1;        end
      4'h4: begin lf = ~(sa & sb);  t1 = sa;        t2 = sa & ~sb;  end
      4'h5: begin lf = ~sb;         t1 = sa | sb;   t2 = sa & ~sb;  end
      4'h6: begin lf = sa ^ sb;     t1 = sa;        t2 = ~sb;       end
      4'h7: begin lf = sa & ~sb;    t1 = sa & ~sb;  t2 = '1;        end
      4'h8: begin lf = ~sa | sb;    t1 = sa;        t2 = sa & sb;   end
      4'h9: begin lf = ~(sa ^ sb);  t1 = sa;        t2 = sb;        end
      4'hA: begin lf = sb;          t1 = sa | ~sb;  t2 = sa & sb;   end
      4'hB: begin lf = sa & sb;     t1 = sa & sb;   t2 = '1;        end
      4'hC: begin lf = '1;          t1 = sa;        t2 = sa;        end
      4'hD: begin lf = sa | ~sb;    t1 = sa | sb;   t2 = sa;        end
      4'hE: begin lf = sa | sb;     t1 = sa | ~sb;  t2 = sa;        end
      default: begin lf = sa;       t1 = sa;        t2 = '1;        end
    endcase
    for (int i = 0; i < SLICE; i++) begin
`ifdef ALU_OVF_EN
      if (i == SLICE - 1) c_msb = c;
`endif
      csum[i] = t1[i] ^ t2[i] ^ c;
      c       = (t1[i] & t2[i]) | (c & (t1[i] ^ t2[i]));
    end
    slice_f = m_q ? lf : csum;
    slice_c = m_q ? 1'b0 : c;
`ifdef ALU_OVF_EN
    slice_cm = m_q ? 1'b0 : c_msb;
`endif
    shadow_d = shadow_q;
    shadow_d[cnt_q*SLICE +: SLICE] = slice_f;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      default: if (last)  state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      s_q      <= '0;
      m_q      <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      shadow_q <= '0;
      f        <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      done     <= 1'b0;
`ifdef ALU_OVF_EN
      ovf      <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state_q == IDLE) begin
        if (start) begin
          a_q     <= a;
          b_q     <= b;
          s_q     <= s;
          m_q     <= m;
          carry_q <= m ? 1'b0 : cin;
          cnt_q   <= '0;
        end
      end else begin
        shadow_q <= shadow_d;
        carry_q  <= slice_c;
        cnt_q    <= cnt_q + 1'b1;
        if (last) begin
          f    <= shadow_d;
          cout <= slice_c;
          zero <= (shadow_d == '0);
          done <= 1'b1;
`ifdef ALU_OVF_EN
          ovf  <= slice_c ^ slice_cm;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_bitslice_seq.sv
// Self-checking bench for alu_bitslice_seq: directed vectors, handshake timing, reset abort and randomized ops
// against a full-width arithmetic reference model. Define ALU_OVF_EN to also check ovf.
module tb_alu_bitslice_seq;

  localparam int WIDTH = 8;
  localparam int SLICE = 2;
  localparam int N     = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0;
  logic [3:0]       s = '0;
  logic             m = 1'b0, cin = 1'b0;
  logic             busy, done, cout, zero;
  logic [WIDTH-1:0] f;
`ifdef ALU_OVF_EN
  logic             ovf;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  alu_bitslice_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .s(s), .m(m), .cin(cin),
    .busy(busy), .done(done), .f(f), .cout(cout), .zero(zero)
`ifdef ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  // Full-width reference: the 74181 tables applied to whole operands with plain addition.
  function automatic void ref_alu(input logic [WIDTH-1:0] ai, bi, input logic [3:0] si,
                                  input logic mi, ci, output logic [WIDTH-1:0] fo,
                                  output logic co, output logic oo);
    logic [WIDTH-1:0] ones, x, y;
    logic [WIDTH:0]   sum, low, mask;
    ones = '1;
    x = '0; y = '0;
    case (si)
      4'h0: begin x = ai;       y = '0;       fo = ~ai;        end
      4'h1: begin x = ai | bi;  y = '0;       fo = ~(ai | bi); end
      4'h2: begin x = ai | ~bi; y = '0;       fo = ~ai & bi;   end
      4'h3: begin x = '0;       y = ones;     fo = '0;         end
      4'h4: begin x = ai;       y = ai & ~bi; fo = ~(ai & bi); end
      4'h5: begin x = ai | bi;  y = ai & ~bi; fo = ~bi;        end
      4'h6: begin x = ai;       y = ~bi;      fo = ai ^ bi;    end
      4'h7: begin x = ai & ~bi; y = ones;     fo = ai & ~bi;   end
      4'h8: begin x = ai;       y = ai & bi;  fo = ~ai | bi;   end
      4'h9: begin x = ai;       y = bi;       fo = ~(ai ^ bi); end
      4'hA: begin x = ai | ~bi; y = ai & bi;  fo = bi;         end
      4'hB: begin x = ai & bi;  y = ones;     fo = ai & bi;    end
      4'hC: begin x = ai;       y = ai;       fo = ones;       end
      4'hD: begin x = ai | bi;  y = ai;       fo = ai | ~bi;   end
      4'hE: begin x = ai | ~bi; y = ai;       fo = ai | bi;    end
      default: begin x = ai;    y = ones;     fo = ai;         end
    endcase
    if (mi) begin
      co = 1'b0;
      oo = 1'b0;
    end else begin
      sum  = {1'b0, x} + {1'b0, y} + ci;
      mask = (1 << (WIDTH - 1)) - 1;
      low  = ({1'b0, x} & mask) + ({1'b0, y} & mask) + ci;
      fo   = sum[WIDTH-1:0];
      co   = sum[WIDTH];
      oo   = low[WIDTH-1] ^ sum[WIDTH];
    end
  endfunction

  task automatic launch(input string name, input logic [WIDTH-1:0] ai, bi,
                        input logic [3:0] si, input logic mi, ci);
    a = ai; b = bi; s = si; m = mi; cin = ci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    tests_run++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s start: busy=%b done=%b, required busy=1 done=0", name, busy, done);
    end
  endtask

  // Walks the N RUN edges, requiring busy through edge N-1 and done exactly after edge N.
  task automatic wait_done(input string name);
    for (int i = 1; i <= N; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (busy !== (i < N) || done !== (i == N)) begin
        tests_failed++;
        $display("FAIL %s edge %0d: busy=%b done=%b, required busy=%b done=%b",
                 name, i, busy, done, (i < N), (i == N));
      end
    end
  endtask

  task automatic run_op(input string name, input logic [WIDTH-1:0] ai, bi, input logic [3:0] si,
                        input logic mi, ci, input logic [WIDTH-1:0] ef, input logic ec, ez, eo,
                        input bit scramble);
    launch(name, ai, bi, si, mi, ci);
    if (scramble) begin
      a = WIDTH'($urandom); b = WIDTH'($urandom); s = 4'($urandom); m = 1'($urandom); cin = 1'($urandom);
    end
    wait_done(name);
    tests_run++;
    if (f !== ef || cout !== ec || zero !== ez) begin
      tests_failed++;
      $display("FAIL %s result: f=%h cout=%b zero=%b, required f=%h cout=%b zero=%b",
               name, f, cout, zero, ef, ec, ez);
    end
`ifdef ALU_OVF_EN
    tests_run++;
    if (ovf !== eo) begin
      tests_failed++;
      $display("FAIL %s ovf: got %b, required %b", name, ovf, eo);
    end
`else
    if (eo === 1'bx) $display("[TB] %s: unexpected X overflow expectation", name);
`endif
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || f !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: busy=%b done=%b f=%h cout=%b zero=%b, required all 0",
               busy, done, f, cout, zero);
    end
`ifdef ALU_OVF_EN
    tests_run++;
    if (ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset ovf: got %b, required 0", ovf);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    run_op("add_1_2",     8'h01, 8'h02, 4'b1001, 1'b0, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("add_wrap",    8'hFF, 8'h01, 4'b1001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    run_op("sub_cin1",    8'h05, 8'h03, 4'b0110, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("sub_cin0",    8'h05, 8'h03, 4'b0110, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    run_op("logic_xor",   8'hA5, 8'h0F, 4'b0110, 1'b1, 1'b0, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("logic_zero",  8'hA5, 8'h0F, 4'b0011, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    run_op("logic_ones",  8'h3C, 8'hC3, 4'b1100, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("minus1_cin0", 8'h12, 8'h34, 4'b0011, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    run_op("minus1_cin1", 8'h12, 8'h34, 4'b0011, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef ALU_OVF_EN
    run_op("ovf_7f_1",    8'h7F, 8'h01, 4'b1001, 1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
  endtask

  task automatic test_ignore_start();
    launch("ignore", 8'h12, 8'h34, 4'b1001, 1'b0, 1'b0);
    a = 8'hFF; b = 8'hFF; s = 4'b1100; m = 1'b1; start = 1'b1;
    wait_done("ignore");
    start = 1'b0;
    tests_run++;
    if (f !== 8'h46 || cout !== 1'b0 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore result: f=%h cout=%b zero=%b, required f=46 cout=0 zero=0", f, cout, zero);
    end
    @(posedge clk); #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore idle: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 8'h10, 8'h20, 4'b1001, 1'b0, 1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b done_before_start: got %b, required 1", done);
    end
    run_op("b2b_second", 8'hF0, 8'h0F, 4'b1110, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_midop();
    int saw = 0;
    launch("abort", 8'h33, 8'h11, 4'b1001, 1'b0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || f !== '0 || cout !== 1'b0 || zero !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort: busy=%b done=%b f=%h cout=%b zero=%b, required all 0",
               busy, done, f, cout, zero);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < N + 2; i++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) saw++;
    end
    tests_run++;
    if (saw != 0) begin
      tests_failed++;
      $display("FAIL abort quiet: %0d cycles with busy/done high, required 0", saw);
    end
    run_op("after_abort", 8'h33, 8'h11, 4'b1001, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] ra, rb, ef;
    logic [3:0]       rs;
    logic             rm, rc, ec, eo;
    for (int i = 0; i < 80; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rs = 4'($urandom);
      rm = 1'($urandom);     rc = 1'($urandom);
      if (i % 8 == 0) ra = '1;
      ref_alu(ra, rb, rs, rm, rc, ef, ec, eo);
      run_op($sformatf("rand%0d", i), ra, rb, rs, rm, rc, ef, ec, (ef == '0), eo, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
